// File: rtl/frame_buffer_arbiter.sv
// Purpose : owns the 128x64 SSD1306 frame buffer (one byte per 8-pixel column segment).
//           It serves a free-running display read port, round-robins two write requesters
//           (A: CPU, B: text/graphics engine) onto one write port, and runs a clear sweep.
// Latency : read data is one cycle after pixelAddress. A winning write commits on the grant
//           edge, and its ack pulses in the following cycle. A clear takes DEPTH cycles.
// Backpr. : requesters hold req/addr/data until ack. Requests stall without ack while a clear
//           runs. The read port is never stalled.
// Ports   : clk/rst_n (async active-low); pixelAddress -> pixelData (display read);
//           reqA/addrA/dataA -> ackA and reqB/addrB/dataB -> ackB (write requesters);
//           clearStart -> busy, clearDone (clear sweep control/status).
module frame_buffer_arbiter #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [7:0]  CLEAR_VALUE = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pixelAddress,
    output logic [7:0]            pixelData,
    input  logic                  reqA,
    input  logic [ADDR_WIDTH-1:0] addrA,
    input  logic [7:0]            dataA,
    output logic                  ackA,
    input  logic                  reqB,
    input  logic [ADDR_WIDTH-1:0] addrB,
    input  logic [7:0]            dataB,
    output logic                  ackB,
    input  logic                  clearStart,
    output logic                  busy,
    output logic                  clearDone
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [ADDR_WIDTH-1:0] clr_addr_next;
    logic                  ptr_b;        // 0: A wins the next contention, 1: B wins
    logic                  ptr_b_next;
    logic                  ack_a_next;
    logic                  ack_b_next;
    logic                  done_next;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;

    logic                  elig_a;
    logic                  elig_b;

    logic [7:0]            mem [DEPTH];

    // A port whose ack is showing already had its write committed last edge; masking it
    // here keeps a still-high req from writing twice.
    assign elig_a = reqA & ~ackA;
    assign elig_b = reqB & ~ackB;

    assign busy = (state == ST_CLEAR);

    // Storage has no reset. The read is registered and sees the pre-write byte on a
    // same-address collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixelData <= 8'h00;
        end else begin
            pixelData <= mem[pixelAddress];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            clr_addr  <= '0;
            ptr_b     <= 1'b0;
            ackA      <= 1'b0;
            ackB      <= 1'b0;
            clearDone <= 1'b0;
        end else begin
            state     <= state_next;
            clr_addr  <= clr_addr_next;
            ptr_b     <= ptr_b_next;
            ackA      <= ack_a_next;
            ackB      <= ack_b_next;
            clearDone <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        clr_addr_next = clr_addr;
        ptr_b_next    = ptr_b;
        ack_a_next    = 1'b0;
        ack_b_next    = 1'b0;
        done_next     = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = clr_addr;
        wr_data       = CLEAR_VALUE;

        case (state)
            ST_IDLE: begin
                if (clearStart) begin
                    // The clear request pre-empts both requesters this cycle.
                    state_next    = ST_CLEAR;
                    clr_addr_next = '0;
                end else if (elig_a && elig_b) begin
                    ack_a_next = ~ptr_b;
                    ack_b_next = ptr_b;
                    ptr_b_next = ~ptr_b;
                end else begin
                    // A lone requester wins without moving the pointer.
                    ack_a_next = elig_a;
                    ack_b_next = elig_b;
                end

                if (ack_a_next) begin
                    wr_en   = 1'b1;
                    wr_addr = addrA;
                    wr_data = dataA;
                end else if (ack_b_next) begin
                    wr_en   = 1'b1;
                    wr_addr = addrB;
                    wr_data = dataB;
                end
            end

            ST_CLEAR: begin
                wr_en = 1'b1;
                // The terminal count is at all-ones, so the counter never wraps.
                if (&clr_addr) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    clr_addr_next = clr_addr + ADDR_ONE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
module tb_frame_buffer_arbiter;

    localparam int         DEPTH = 1024;
    localparam logic [7:0] CLRV  = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] pixelAddress = '0;
    logic [7:0] pixelData;
    logic       reqA = 1'b0;
    logic [9:0] addrA = '0;
    logic [7:0] dataA = '0;
    logic       ackA;
    logic       reqB = 1'b0;
    logic [9:0] addrB = '0;
    logic [7:0] dataB = '0;
    logic       ackB;
    logic       clearStart = 1'b0;
    logic       busy;
    logic       clearDone;

    int total = 0;
    int bad   = 0;

    frame_buffer_arbiter #(.ADDR_WIDTH(10), .CLEAR_VALUE(CLRV)) dut (
        .clk(clk), .rst_n(rst_n),
        .pixelAddress(pixelAddress), .pixelData(pixelData),
        .reqA(reqA), .addrA(addrA), .dataA(dataA), .ackA(ackA),
        .reqB(reqB), .addrB(addrB), .dataB(dataB), .ackB(ackB),
        .clearStart(clearStart), .busy(busy), .clearDone(clearDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Memory is tracked as a byte array with a known-flag per byte. Requests are served
    // by a "who is owed the next tie" flag. A clear is a countdown of remaining bytes.
    logic [7:0] m_mem   [DEPTH];
    bit         m_known [DEPTH];
    bit         e_pix_ok   = 1'b1;
    logic [7:0] e_pix      = 8'h00;
    bit         e_acka     = 1'b0;
    bit         e_ackb     = 1'b0;
    bit         e_busy     = 1'b0;
    bit         e_done     = 1'b0;
    bit         a_owed_tie = 1'b1;
    int         clr_next   = 0;
    bit         clearing   = 1'b0;
    bit         want_a, want_b, win_a, win_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_pix_ok = 1'b1; e_pix = 8'h00;
            e_acka = 1'b0; e_ackb = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            a_owed_tie = 1'b1; clearing = 1'b0; clr_next = 0;
        end else begin
            e_pix_ok = m_known[pixelAddress];
            e_pix    = m_mem[pixelAddress];
            win_a = 1'b0; win_b = 1'b0; e_done = 1'b0;
            if (clearing) begin
                m_mem[clr_next] = CLRV; m_known[clr_next] = 1'b1;
                clr_next++;
                if (clr_next == DEPTH) begin
                    clearing = 1'b0; e_done = 1'b1;
                end
            end else if (clearStart) begin
                clearing = 1'b1; clr_next = 0;
            end else begin
                want_a = reqA && !e_acka;
                want_b = reqB && !e_ackb;
                if (want_a && want_b) begin
                    win_a = a_owed_tie; win_b = !a_owed_tie;
                    a_owed_tie = !a_owed_tie;
                end else begin
                    win_a = want_a; win_b = want_b;
                end
                if (win_a) begin m_mem[addrA] = dataA; m_known[addrA] = 1'b1; end
                if (win_b) begin m_mem[addrB] = dataB; m_known[addrB] = 1'b1; end
            end
            e_acka = win_a; e_ackb = win_b; e_busy = clearing;
        end
    end

    always @(posedge clk) begin
        #2;
        check("m_ackA", ackA, e_acka);
        check("m_ackB", ackB, e_ackb);
        check("m_busy", busy, e_busy);
        check("m_clearDone", clearDone, e_done);
        if (e_pix_ok) check("m_pixelData", pixelData, e_pix);
    end

    // ---------------- directed stimulus ----------------
    task automatic write_a(input logic [9:0] a, input logic [7:0] d);
        int n;
        @(negedge clk);
        reqA = 1'b1; addrA = a; dataA = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!ackA && n < 50);
        check("wr_ackA", ackA, 1);
        reqA = 1'b0;
    endtask

    task automatic read(input logic [9:0] a, output logic [7:0] d);
        @(negedge clk);
        pixelAddress = a;
        @(negedge clk);
        d = pixelData;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit expired");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int n, na, nb;
        bit saw_ack;

        repeat (3) @(negedge clk);
        check("rst_pixelData", pixelData, 0);
        check("rst_ackA", ackA, 0);
        check("rst_ackB", ackB, 0);
        check("rst_busy", busy, 0);
        check("rst_clearDone", clearDone, 0);
        rst_n = 1'b1;

        // 1: write then read back through the display port
        write_a(10'h000, 8'hA5);
        read(10'h000, rd);
        check("t1_read0", rd, 8'hA5);

        // 2: simultaneous requests right after reset, A preferred
        pulse_reset();
        @(negedge clk);
        reqA = 1'b1; addrA = 10'h010; dataA = 8'h11;
        reqB = 1'b1; addrB = 10'h020; dataB = 8'h22;
        @(negedge clk);
        check("t2_c1_ackA", ackA, 1);
        check("t2_c1_ackB", ackB, 0);
        reqA = 1'b0;
        @(negedge clk);
        check("t2_c2_ackA", ackA, 0);
        check("t2_c2_ackB", ackB, 1);
        reqB = 1'b0;
        read(10'h010, rd); check("t2_mem010", rd, 8'h11);
        read(10'h020, rd); check("t2_mem020", rd, 8'h22);

        // 3: both held for 8 writes -> strict alternation
        pulse_reset();
        @(negedge clk);
        reqA = 1'b1; addrA = 10'h030; dataA = 8'h33;
        reqB = 1'b1; addrB = 10'h040; dataB = 8'h44;
        na = 0; nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t3_ackA_seq", ackA, (i % 2 == 0) ? 1 : 0);
            check("t3_ackB_seq", ackB, (i % 2 == 1) ? 1 : 0);
            na += int'(ackA); nb += int'(ackB);
        end
        reqA = 1'b0; reqB = 1'b0;
        check("t3_countA", na, 4);
        check("t3_countB", nb, 4);

        // 4: clear with A pending
        @(negedge clk);
        reqA = 1'b1; addrA = 10'h077; dataA = 8'h5A; clearStart = 1'b1;
        @(negedge clk);
        clearStart = 1'b0;
        n = 0; saw_ack = 1'b0;
        while (busy && n < 3000) begin
            if (ackA) saw_ack = 1'b1;
            n++;
            @(negedge clk);
        end
        check("t4_busy_cycles", n, 1024);
        check("t4_no_ack_while_busy", saw_ack, 0);
        check("t4_clearDone", clearDone, 1);
        check("t4_ackA_not_yet", ackA, 0);
        @(negedge clk);
        check("t4_ackA_after", ackA, 1);
        check("t4_clearDone_pulse", clearDone, 0);
        reqA = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            read(a[9:0], rd);
            check("t4_sweep", rd, (a == 'h077) ? 8'h5A : CLRV);
        end

        // 5: same-address read/write collision
        @(negedge clk);
        pixelAddress = 10'h155;
        reqA = 1'b1; addrA = 10'h155; dataA = 8'h3C;
        @(negedge clk);
        check("t5_old_byte", pixelData, 8'h00);
        check("t5_ackA", ackA, 1);
        reqA = 1'b0;
        @(negedge clk);
        check("t5_new_byte", pixelData, 8'h3C);

        // 6: reset in the middle of a clear sweep
        write_a(10'h000, 8'h99);
        write_a(10'h1FF, 8'hE1);
        write_a(10'h200, 8'hE2);
        write_a(10'h3FF, 8'hE3);
        @(negedge clk); clearStart = 1'b1;
        @(negedge clk); clearStart = 1'b0;
        repeat (512) @(negedge clk);   // bytes 0x000..0x1FF written
        check("t6_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_busy_abort", busy, 0);
        check("t6_no_done_abort", clearDone, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_no_done_after", clearDone, 0);
        read(10'h000, rd); check("t6_mem000", rd, CLRV);
        read(10'h1FF, rd); check("t6_mem1FF", rd, CLRV);
        read(10'h200, rd); check("t6_mem200", rd, 8'hE2);
        read(10'h3FF, rd); check("t6_mem3FF", rd, 8'hE3);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
